// File: rtl/arb_req_pkg.sv
// Shared types and defaults for the requester side of the 2-way fixed-priority arbiter.
package arb_req_pkg;

  localparam int NUM_CH        = 2;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_PEND_W    = 4;
  localparam int DEF_TIMEOUT   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } req_state_t;

endpackage

// File: rtl/arb_req_if.sv
// Requester <-> arbiter/job-source bundle. master = requester, slave = environment.
interface arb_req_if
  import arb_req_pkg::*;
#(
  parameter int PEND_W = DEF_PEND_W
);

  logic [NUM_CH-1:0] job_push;
  logic [NUM_CH-1:0] grant;
  logic [NUM_CH-1:0] request;
  logic [NUM_CH-1:0] beat_valid;
  logic [NUM_CH-1:0] beat_last;
  logic [NUM_CH-1:0] job_done;
  logic [PEND_W-1:0] pending0;
  logic [PEND_W-1:0] pending1;
  logic [NUM_CH-1:0] job_full;
  logic [NUM_CH-1:0] overflow_err;
  logic [NUM_CH-1:0] starve_err;

  modport master (
    input  job_push, grant,
    output request, beat_valid, beat_last, job_done,
           pending0, pending1, job_full, overflow_err, starve_err
  );

  modport slave (
    output job_push, grant,
    input  request, beat_valid, beat_last, job_done,
           pending0, pending1, job_full, overflow_err, starve_err
  );

endinterface

// File: rtl/arb_req_channel.sv
// One requester channel: job queue counter, request/burst FSM, beat and starvation counters.
module arb_req_channel
  import arb_req_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int PEND_W    = DEF_PEND_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_grant,
  output logic              o_request,
  output logic              o_beat_valid,
  output logic              o_beat_last,
  output logic              o_job_done,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_job_full,
  output logic              o_overflow_err,
  output logic              o_starve_err
);

  // The +1 keeps the counters at least one bit wide when BURST_LEN or TIMEOUT is 1.
  localparam int BEAT_W   = $clog2(BURST_LEN) + 1;
  localparam int STARVE_W = $clog2(TIMEOUT) + 1;

  localparam logic [PEND_W-1:0]   PEND_MAX   = '1;
  localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(TIMEOUT - 1);

  req_state_t          r_state;
  logic [PEND_W-1:0]   r_pending;
  logic [BEAT_W-1:0]   r_beat_cnt;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic                r_overflow_err;
  logic                r_starve_err;

  logic [PEND_W-1:0]   w_pending_nxt;
  logic                w_overflow;
  logic                w_dec;
  logic                w_beat;
  logic                w_last;

  assign w_dec  = (r_state == REL);
  assign w_beat = (r_state == XFER) && i_grant;
  assign w_last = w_beat && (r_beat_cnt == BEAT_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_pending_nxt = r_pending;
    w_overflow    = 1'b0;
    case ({i_push, w_dec})
      2'b10: begin
        if (r_pending == PEND_MAX) w_overflow    = 1'b1;
        else                       w_pending_nxt = r_pending + PEND_W'(1);
      end
      2'b01:   w_pending_nxt = r_pending - PEND_W'(1);
      default: w_pending_nxt = r_pending;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pending      <= '0;
      r_beat_cnt     <= '0;
      r_starve_cnt   <= '0;
      r_overflow_err <= 1'b0;
      r_starve_err   <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_overflow) r_overflow_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_pending_nxt != '0) r_state <= REQ;
        end
        REQ: begin
          if (i_grant) begin
            r_state      <= XFER;
            r_beat_cnt   <= '0;
            r_starve_cnt <= '0;
          end else if (r_starve_cnt == STARVE_LIM) begin
            r_starve_err <= 1'b1;
          end else begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
          end
        end
        XFER: begin
          // A dropped grant is preemption by the other channel: hold the beat count.
          if (w_last) begin
            r_state    <= REL;
            r_beat_cnt <= '0;
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
          end
        end
        REL: begin
          r_state <= (w_pending_nxt != '0) ? REQ : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_request      = (r_state == REQ) || (r_state == XFER);
  assign o_beat_valid   = w_beat;
  assign o_beat_last    = w_last;
  assign o_job_done     = w_dec;
  assign o_pending      = r_pending;
  assign o_job_full     = (r_pending == PEND_MAX);
  assign o_overflow_err = r_overflow_err;
  assign o_starve_err   = r_starve_err;

endmodule

// File: rtl/arb_requester.sv
// Two independent requester channels presented to the arbiter as one bundle.
module arb_requester
  import arb_req_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int PEND_W    = DEF_PEND_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic     clk,
  input  logic     rst_n,
  arb_req_if.master bus
);

  logic [NUM_CH-1:0] w_request;
  logic [NUM_CH-1:0] w_beat_valid;
  logic [NUM_CH-1:0] w_beat_last;
  logic [NUM_CH-1:0] w_job_done;
  logic [NUM_CH-1:0] w_job_full;
  logic [NUM_CH-1:0] w_overflow_err;
  logic [NUM_CH-1:0] w_starve_err;
  logic [PEND_W-1:0] w_pending [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    arb_req_channel #(
      .BURST_LEN (BURST_LEN),
      .PEND_W    (PEND_W),
      .TIMEOUT   (TIMEOUT)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_push         (bus.job_push[g]),
      .i_grant        (bus.grant[g]),
      .o_request      (w_request[g]),
      .o_beat_valid   (w_beat_valid[g]),
      .o_beat_last    (w_beat_last[g]),
      .o_job_done     (w_job_done[g]),
      .o_pending      (w_pending[g]),
      .o_job_full     (w_job_full[g]),
      .o_overflow_err (w_overflow_err[g]),
      .o_starve_err   (w_starve_err[g])
    );
  end

  assign bus.request      = w_request;
  assign bus.beat_valid   = w_beat_valid;
  assign bus.beat_last    = w_beat_last;
  assign bus.job_done     = w_job_done;
  assign bus.job_full     = w_job_full;
  assign bus.overflow_err = w_overflow_err;
  assign bus.starve_err   = w_starve_err;
  assign bus.pending0     = w_pending[0];
  assign bus.pending1     = w_pending[1];

endmodule
